// File: rtl/distance_filter.sv
// -----------------------------------------------------------------------------
// distance_filter
//   Smooths ultrasonic distance samples with a 4-sample moving average and
//   classifies the result into GO / SLOW / STOP zones with hysteresis.
//
//   Optional feature: define DIST_FILTER_TIMEOUT_EN to build the stale-data
//   watchdog. Without it, stale is constant 0 and no watchdog logic exists.
//
// Parameters
//   NEAR_CM        STOP threshold (cm)
//   FAR_CM         SLOW threshold (cm), FAR_CM > NEAR_CM + HYST_CM
//   HYST_CM        hysteresis margin (cm)
//   TIMEOUT_CYCLES watchdog limit in clk cycles
//
// Ports
//   clk           system clock
//   rst           asynchronous active-high reset
//   sample_valid  one-cycle strobe qualifying distance_in
//   distance_in   measured distance (cm); 0 means echo timeout, discarded
//   avg_distance  4-sample moving average (truncated)
//   zone          0=GO, 1=SLOW, 2=STOP
//   stop          high while zone is STOP
//   filt_valid    one-cycle pulse when avg_distance/zone update
//   stale         watchdog expired (0 when the watchdog is not built)
// -----------------------------------------------------------------------------
module distance_filter #(
    parameter int NEAR_CM        = 20,
    parameter int FAR_CM         = 40,
    parameter int HYST_CM        = 3,
    parameter int TIMEOUT_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_valid,
    input  logic [7:0] distance_in,
    output logic [7:0] avg_distance,
    output logic [1:0] zone,
    output logic       stop,
    output logic       filt_valid,
    output logic       stale
);

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } fill_state_t;

    typedef enum logic [1:0] {
        Z_GO   = 2'd0,
        Z_SLOW = 2'd1,
        Z_STOP = 2'd2
    } zone_t;

    // Thresholds widened by one bit so comparisons against the 8-bit
    // average stay correct for any threshold up to 511.
    localparam logic [8:0] L_NEAR      = 9'(NEAR_CM);
    localparam logic [8:0] L_FAR       = 9'(FAR_CM);
    localparam logic [8:0] L_NEAR_HYST = 9'(NEAR_CM + HYST_CM);
    localparam logic [8:0] L_FAR_HYST  = 9'(FAR_CM + HYST_CM);

    fill_state_t r_state;
    fill_state_t w_state_next;
    logic [7:0]  r_buf [4];
    logic [1:0]  r_wptr;
    logic [1:0]  r_fill_cnt;
    logic [9:0]  r_sum;
    logic [7:0]  r_avg;
    zone_t       r_zone;
    logic        r_filt_valid;

    logic        w_accept;
    logic        w_update;
    logic [9:0]  w_sum_next;
    logic [7:0]  w_avg_next;
    logic [8:0]  w_avg_ext;
    zone_t       w_zone_eval;
    logic        w_expire;

    assign w_accept = sample_valid && (distance_in != '0);

    // The oldest entry is overwritten by the new sample, so it leaves the sum.
    // During FILL the buffer still holds reset zeros, so the same update works.
    assign w_sum_next = r_sum + {2'b00, distance_in} - {2'b00, r_buf[r_wptr]};
    assign w_avg_next = w_sum_next[9:2];
    assign w_avg_ext  = {1'b0, w_avg_next};

    // Fill FSM: next-state logic and the "publish" decision.
    always_comb begin
        w_state_next = r_state;
        w_update     = 1'b0;
        case (r_state)
            S_FILL: begin
                if (w_accept && (r_fill_cnt == 2'd3)) begin
                    w_state_next = S_RUN;
                    w_update     = 1'b1;
                end
            end
            S_RUN: begin
                w_update = w_accept;
            end
            default: w_state_next = S_FILL;
        endcase
    end

    // Zone evaluated on the new average, starting from the current zone.
    always_comb begin
        w_zone_eval = r_zone;
        case (r_zone)
            Z_GO: begin
                if (w_avg_ext < L_NEAR)
                    w_zone_eval = Z_STOP;
                else if (w_avg_ext < L_FAR)
                    w_zone_eval = Z_SLOW;
            end
            Z_SLOW: begin
                if (w_avg_ext < L_NEAR)
                    w_zone_eval = Z_STOP;
                else if (w_avg_ext >= L_FAR_HYST)
                    w_zone_eval = Z_GO;
            end
            Z_STOP: begin
                if (w_avg_ext >= L_FAR_HYST)
                    w_zone_eval = Z_GO;
                else if (w_avg_ext >= L_NEAR_HYST)
                    w_zone_eval = Z_SLOW;
            end
            default: w_zone_eval = Z_STOP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_FILL;
        else
            r_state <= w_state_next;
    end

    // Sample buffer, running sum and fill counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++)
                r_buf[i] <= '0;
            r_wptr     <= '0;
            r_fill_cnt <= '0;
            r_sum      <= '0;
        end else if (w_accept) begin
            r_buf[r_wptr] <= distance_in;
            r_wptr        <= r_wptr + 2'd1;
            r_sum         <= w_sum_next;
            if (r_state == S_FILL)
                r_fill_cnt <= r_fill_cnt + 2'd1;
        end
    end

    // Published outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_avg        <= '0;
            r_zone       <= Z_STOP;
            r_filt_valid <= 1'b0;
        end else begin
            r_filt_valid <= w_update;
            if (w_update) begin
                r_avg  <= w_avg_next;
                r_zone <= w_zone_eval;
            end else if (w_expire) begin
                r_zone <= Z_STOP;
            end
        end
    end

`ifdef DIST_FILTER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] L_WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_stale;

    // Fires once when the saturated counter is seen and no sample arrives;
    // a sample arriving in that same cycle wins.
    assign w_expire = !w_accept && !r_stale && (r_wd_cnt == L_WD_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt <= '0;
            r_stale  <= 1'b0;
        end else begin
            if (w_accept)
                r_wd_cnt <= '0;
            else if (r_wd_cnt != L_WD_LIMIT)
                r_wd_cnt <= r_wd_cnt + 1'b1;

            if (w_accept)
                r_stale <= 1'b0;
            else if (w_expire)
                r_stale <= 1'b1;
        end
    end

    assign stale = r_stale;
`else
    assign w_expire = 1'b0;
    assign stale    = 1'b0;
`endif

    assign avg_distance = r_avg;
    assign zone         = r_zone;
    assign stop         = (r_zone == Z_STOP);
    assign filt_valid   = r_filt_valid;

endmodule

// File: tb/tb_distance_filter.sv
// -----------------------------------------------------------------------------
// tb_distance_filter
//   Directed bench for distance_filter. Each sample step pushes the expected
//   average/zone to a queue; a monitor pops and compares whenever filt_valid
//   is seen, and flags any filt_valid that nothing expected.
// -----------------------------------------------------------------------------
module tb_distance_filter;

    localparam logic [1:0] GO   = 2'd0;
    localparam logic [1:0] SLOW = 2'd1;
    localparam logic [1:0] STOP = 2'd2;

    logic       clk;
    logic       rst;
    logic       sample_valid;
    logic [7:0] distance_in;
    logic [7:0] avg_distance;
    logic [1:0] zone;
    logic       stop;
    logic       filt_valid;
    logic       stale;

    typedef struct {
        logic [7:0] avg;
        logic [1:0] zone;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    distance_filter #(
        .NEAR_CM(20),
        .FAR_CM(40),
        .HYST_CM(3),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sample_valid(sample_valid),
        .distance_in(distance_in),
        .avg_distance(avg_distance),
        .zone(zone),
        .stop(stop),
        .filt_valid(filt_valid),
        .stale(stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: samples away from the active edge.
    always @(negedge clk) begin
        if (!rst && filt_valid) begin
            check("filt_valid_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("avg_distance", 32'(avg_distance), 32'(e.avg));
                check("zone", 32'(zone), 32'(e.zone));
                check("stop", 32'(stop), 32'(e.zone == STOP));
                check("latency", cyc, e.cyc + 1);
            end
        end
    end

    // Drive one sample; when fv is set, an update is expected one clk later.
    task automatic send(input logic [7:0] din, input bit fv,
                        input logic [7:0] eavg, input logic [1:0] ezone);
        exp_t e;
        @(negedge clk);
        sample_valid = 1'b1;
        distance_in  = din;
        if (fv) begin
            e.avg  = eavg;
            e.zone = ezone;
            e.cyc  = cyc;
            exp_q.push_back(e);
        end
        @(negedge clk);
        sample_valid = 1'b0;
        distance_in  = '0;
        @(negedge clk);
        check("no_missing_update", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_avg"}, 32'(avg_distance), 32'd0);
        check({tag, "_zone"}, 32'(zone), 32'(STOP));
        check({tag, "_stop"}, 32'(stop), 32'd1);
        check({tag, "_fv"}, 32'(filt_valid), 32'd0);
        check({tag, "_stale"}, 32'(stale), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "time limit reached");
    end

    initial begin
        int waited;
        rst          = 1'b1;
        sample_valid = 1'b0;
        distance_in  = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Fill with 100s: nothing published until the 4th sample.
        send(8'd100, 1'b0, '0, '0);
        send(8'd100, 1'b0, '0, '0);
        send(8'd100, 1'b0, '0, '0);
        check("fill_avg_hold", 32'(avg_distance), 32'd0);
        check("fill_zone_hold", 32'(zone), 32'(STOP));
        send(8'd100, 1'b1, 8'd100, GO);

        // Approach: 77, 55, 32 (SLOW), 10 (STOP).
        send(8'd10, 1'b1, 8'd77, GO);
        send(8'd10, 1'b1, 8'd55, GO);
        send(8'd10, 1'b1, 8'd32, SLOW);
        send(8'd10, 1'b1, 8'd10, STOP);
        check("approach_stop", 32'(stop), 32'd1);

        // Hysteresis around NEAR+HYST=23 and FAR+HYST=43.
        send(8'd58, 1'b1, 8'd22, STOP);
        send(8'd14, 1'b1, 8'd23, SLOW);
        send(8'd86, 1'b1, 8'd42, SLOW);
        send(8'd14, 1'b1, 8'd43, GO);

        // Zero sample discarded: no update, nothing moves.
        send(8'd0, 1'b0, '0, '0);
        check("zero_avg_hold", 32'(avg_distance), 32'd43);
        check("zero_zone_hold", 32'(zone), 32'(GO));
        // Replacing the untouched oldest (58) with 58 must keep avg at 43.
        send(8'd58, 1'b1, 8'd43, GO);

        // Reset mid-run after two more samples.
        send(8'd14, 1'b1, 8'd43, GO);
        send(8'd86, 1'b1, 8'd43, GO);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrun_reset");
        @(negedge clk);
        rst = 1'b0;
        send(8'd50, 1'b0, '0, '0);
        send(8'd50, 1'b0, '0, '0);
        send(8'd50, 1'b0, '0, '0);
        check("refill_avg_hold", 32'(avg_distance), 32'd0);
        check("refill_zone_hold", 32'(zone), 32'(STOP));
        send(8'd50, 1'b1, 8'd50, GO);

`ifdef DIST_FILTER_TIMEOUT_EN
        waited = 0;
        while (stale !== 1'b1 && waited < 150) begin
            @(negedge clk);
            waited++;
        end
        check("stale_set", 32'(stale), 32'd1);
        check("stale_window", 32'(waited >= 95 && waited <= 105), 32'd1);
        check("stale_zone", 32'(zone), 32'(STOP));
        check("stale_stop", 32'(stop), 32'd1);
        check("stale_fv", 32'(filt_valid), 32'd0);
        send(8'd200, 1'b1, 8'd87, GO);
        check("stale_clear", 32'(stale), 32'd0);
`else
        waited = 0;
        while (waited < 150) begin
            @(negedge clk);
            waited++;
        end
        check("no_watchdog_stale", 32'(stale), 32'd0);
        check("no_watchdog_zone", 32'(zone), 32'(GO));
`endif

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
